wb_spi_master: RTL and testbench
================================

Name: wb_spi_master

Overview:
- Wishbone classic single-cycle initiator that drives the 8-bit register file of the SPI core: 3-bit address, 8-bit data, ack termination, inta interrupt.
- Accepts register read/write commands on a valid/ready command port, runs exactly one Wishbone cycle per command, and returns read data or a timeout error on a valid/ready response port.
- Registers the core's interrupt line and flags its rising edge.
- Sits between test/firmware-model logic and the SPI core's bus slave port.

Parameters:
- TIMEOUT_CYCLES, 16, number of cycles stb_o may stay high without ack_i before the cycle is aborted; legal range 2..255.
- ADR_W, 3, Wishbone address width.
- DAT_W, 8, Wishbone data width.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_W  register address.
- cmd_dat_i  in  DAT_W  write data; ignored for reads.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_dat_o  out  DAT_W  read data; 0 for writes and on error.
- rsp_err_o  out  1  1 = cycle timed out.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- adr_o  out  ADR_W  Wishbone address.
- we_o  out  1  Wishbone write enable.
- dat_o  out  DAT_W  Wishbone write data.
- dat_i  in  DAT_W  Wishbone read data.
- ack_i  in  1  Wishbone acknowledge.
- inta_i  in  1  core interrupt.
- irq_o  out  1  registered copy of inta_i.
- irq_rise_o  out  1  one-cycle pulse on a 0->1 transition of irq_o.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_i high) forces all outputs to 0 and the state to IDLE, and clears the timeout counter. Exception: cmd_ready_o is 0 while rst_i is high and becomes 1 on the first clock edge after release.
- A reset in the middle of a transaction drops cyc_o and stb_o immediately. The pending command is lost and no response is produced.
- All outputs are registered. cyc_o and stb_o are always equal.
- State IDLE:
  - cmd_ready_o = 1.
  - On a cmd_valid_i edge: latch adr, we and dat (dat_o is driven 0 for reads), clear the counter, go to BUS.
- State BUS:
  - cyc_o = stb_o = 1; adr_o, we_o and dat_o are held stable; cmd_ready_o = 0.
  - Each edge with ack_i = 1: capture dat_i into rsp_dat_o if a read (0 if a write), set rsp_err_o = 0, go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: set rsp_err_o = 1 and rsp_dat_o = 0, go to RESP.
  - Else: increment the counter.
  - ack takes priority over timeout on the same edge.
- State RESP:
  - cyc_o = stb_o = 0; rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held.
  - On a rsp_ready_i edge: drop rsp_valid_o, go to IDLE.
  - There is no IDLE bypass, so the minimum spacing between cycles is one idle bus cycle.
- Latency: command accepted at edge N → cyc_o high in cycle N+1. If ack_i arrives in cycle N+k, cyc_o drops and rsp_valid_o rises in cycle N+k+1. With the SPI core (ack one cycle after stb), a command-to-response latency of 3 cycles is required.
- ack_i and dat_i are ignored outside BUS; a stray ack has no effect.
- Timeout: stb_o stays high for exactly TIMEOUT_CYCLES cycles before the abort.
- Interrupt:
  - irq_o <= inta_i every cycle.
  - irq_rise_o <= inta_i & ~irq_o.
  - Independent of the command state machine.
- busy_o = (state != IDLE).

Decomposition:
- Shared package wb_spi_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - ADR_W/DAT_W defaults;
  - SPI core register address constants: SPCR=0, SPSR=1, SPDR=2, SPER=3.
- Optional sub-module wb_irq_edge for the interrupt register and edge detector. All other logic stays in one module.

Test Plan:
- Write: cmd we=1 adr=0 dat=8'h50; responder acks one cycle after stb → cyc_o high for 2 cycles with adr_o=0, dat_o=8'h50, we_o=1; rsp_valid_o with err=0, dat=0, 3 cycles after acceptance.
- Read: cmd we=0 adr=2; responder returns dat_i=8'hA5 with ack → rsp_dat_o=8'hA5, err=0; dat_o=0 throughout.
- Timeout: cmd read adr=1, no ack → stb_o high exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=0; a late ack_i pulse during RESP is ignored.
- Back-pressure/back-to-back: two queued commands with rsp_ready_i held low for 5 cycles → rsp_valid_o and data stable; cmd_ready_o stays 0; second cycle starts only after the response handshake plus one IDLE cycle.
- Reset mid-cycle: assert rst_i during BUS → cyc_o, stb_o, rsp_valid_o go 0 asynchronously, no response; after release, a new write completes normally.
- Interrupt: inta_i low→high held 4 cycles → irq_o follows one cycle later; irq_rise_o high exactly one cycle; no pulse on the falling edge.

Source files
------------

// File: rtl/wb_spi_pkg.sv
// Shared definitions for the Wishbone initiator that drives the SPI core's
// register file: bus width defaults, the command state encoding and the
// core's register map.
package wb_spi_pkg;

  localparam int ADR_W_DEF = 3;
  localparam int DAT_W_DEF = 8;

  // SPI core register addresses
  localparam logic [2:0] SPCR = 3'd0;  // control
  localparam logic [2:0] SPSR = 3'd1;  // status
  localparam logic [2:0] SPDR = 3'd2;  // data
  localparam logic [2:0] SPER = 3'd3;  // extensions

  // Command engine: wait for a command, run one bus cycle, present response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/wb_spi_master_if.sv
// Wishbone classic bus between the initiator and the SPI core slave port,
// plus the core's interrupt line. Signal suffixes are from the initiator's
// point of view.
//   cyc_o/stb_o : cycle and strobe (always equal)
//   adr_o/we_o  : address and write enable
//   dat_o/dat_i : write data / read data
//   ack_i       : cycle termination
//   inta_i      : core interrupt request
interface wb_spi_master_if
  import wb_spi_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) ();

  logic             cyc_o;
  logic             stb_o;
  logic [ADR_W-1:0] adr_o;
  logic             we_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             ack_i;
  logic             inta_i;

  modport master (
    output cyc_o, stb_o, adr_o, we_o, dat_o,
    input  dat_i, ack_i, inta_i
  );

  modport slave (
    input  cyc_o, stb_o, adr_o, we_o, dat_o,
    output dat_i, ack_i, inta_i
  );

endinterface

// File: rtl/wb_irq_edge.sv
// Interrupt register and rising-edge detector for the SPI core's inta line.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   inta_i      : raw interrupt from the core
//   irq_o       : inta_i delayed by one clock
//   irq_rise_o  : one-cycle pulse when irq_o goes 0 -> 1
module wb_irq_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inta_i,
  output logic irq_o,
  output logic irq_rise_o
);

  logic irq_q;
  logic rise_q;

  // The pulse is computed from the incoming level against the registered
  // copy, so it lines up with the cycle in which irq_o first reads 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      irq_q  <= inta_i;
      rise_q <= inta_i & ~irq_q;
    end
  end

  assign irq_o      = irq_q;
  assign irq_rise_o = rise_q;

endmodule

// File: rtl/wb_spi_master.sv
// Wishbone classic single-cycle initiator for the SPI core register file.
// Each command accepted on the cmd port produces exactly one bus cycle and
// one response on the rsp port (read data, or an error if the slave never
// acknowledged within TIMEOUT_CYCLES strobe cycles).
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   : command handshake
//   cmd_we_i/adr_i/dat_i  : command contents (dat ignored for reads)
//   rsp_valid_o/ready_i   : response handshake
//   rsp_dat_o/rsp_err_o   : read data (0 for writes/errors), timeout flag
//   wb                    : Wishbone master port + interrupt input
//   irq_o/irq_rise_o      : registered interrupt and its rising-edge pulse
//   busy_o                : a command is in flight
module wb_spi_master
  import wb_spi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADR_W          = ADR_W_DEF,
  parameter int DAT_W          = DAT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADR_W-1:0]    cmd_adr_i,
  input  logic [DAT_W-1:0]    cmd_dat_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DAT_W-1:0]    rsp_dat_o,
  output logic                rsp_err_o,

  wb_spi_master_if.master     wb,

  output logic                irq_o,
  output logic                irq_rise_o,
  output logic                busy_o
);

  // Last count value before the abort; counter starts at 0 on the first
  // strobe cycle, so stb stays high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q,     state_d;
  logic [7:0]       cnt_q,       cnt_d;
  logic [ADR_W-1:0] adr_q,       adr_d;
  logic             we_q,        we_d;
  logic [DAT_W-1:0] wdat_q,      wdat_d;
  logic [DAT_W-1:0] rdat_q,      rdat_d;
  logic             err_q,       err_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cyc_q,       cyc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q,      busy_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      wdat_q      <= wdat_d;
      rdat_q      <= rdat_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q is still 0 in the first cycle after reset, so a
        // command is only taken once the handshake is actually offered.
        if (cmd_valid_i && cmd_ready_q) begin
          adr_d   = cmd_adr_i;
          we_d    = cmd_we_i;
          wdat_d  = cmd_we_i ? cmd_dat_i : '0;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack wins over a timeout landing on the same edge
        if (wb.ack_i) begin
          rdat_d  = we_q ? '0 : wb.dat_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    cmd_ready_d = (state_d == IDLE);
    cyc_d       = (state_d == BUS);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rdat_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = busy_q;

  // stb shares the cyc register so the two can never disagree.
  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.adr_o = adr_q;
  assign wb.we_o  = we_q;
  assign wb.dat_o = wdat_q;

  wb_irq_edge u_irq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inta_i     (wb.inta_i),
    .irq_o      (irq_o),
    .irq_rise_o (irq_rise_o)
  );

endmodule

// File: tb/tb_wb_spi_master.sv
// Bench for wb_spi_master: directed commands against a simple SPI-core
// responder, a transaction-level reference model checked every cycle, and
// hand-computed expectations for latency, timeout length and interrupts.
module tb_wb_spi_master;
  import wb_spi_pkg::*;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [2:0] cmd_adr = 3'd0;
  logic [7:0] cmd_dat = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_dat;
  logic       rsp_err;
  logic       irq, irq_rise, busy;

  wb_spi_master_if #(.ADR_W(3), .DAT_W(8)) wbif ();

  wb_spi_master #(.TIMEOUT_CYCLES(T), .ADR_W(3), .DAT_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wb          (wbif),
    .irq_o       (irq),
    .irq_rise_o  (irq_rise),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  // ---------------- responder (SPI core stand-in) ----------------
  int         ack_dly = 1;      // ack this many cycles after stb rises; 0 = never
  logic       stray_ack = 1'b0;
  logic [7:0] rd_val = 8'h00;

  initial begin
    int age;
    age = 0;
    wbif.ack_i = 1'b0;
    wbif.dat_i = 8'h3C;
    forever begin
      @(negedge clk);
      if (wbif.stb_o) age = age + 1;
      else            age = 0;
      wbif.ack_i = stray_ack || (ack_dly > 0 && wbif.stb_o && age == ack_dly + 1);
      wbif.dat_i = wbif.ack_i ? rd_val : 8'h3C;
    end
  end

  // ---------------- reference model ----------------
  // Expected value of every output in the cycle after each edge.
  logic       e_ready, e_cyc, e_we, e_rv, e_err, e_busy, e_irq, e_rise;
  logic [2:0] e_adr;
  logic [7:0] e_dat, e_rdat;
  int         m_stb;   // strobe cycles issued so far for the open command

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ready <= 0; e_cyc <= 0; e_we <= 0; e_rv <= 0; e_err <= 0;
      e_busy <= 0; e_irq <= 0; e_rise <= 0; e_adr <= 0; e_dat <= 0;
      e_rdat <= 0; m_stb <= 0;
    end else begin
      e_irq  <= wbif.inta_i;
      e_rise <= wbif.inta_i & ~e_irq;
      if (e_ready && cmd_valid) begin
        e_ready <= 0; e_cyc <= 1; e_busy <= 1;
        e_adr <= cmd_adr; e_we <= cmd_we;
        e_dat <= cmd_we ? cmd_dat : 8'h00;
        m_stb <= 1;
      end else if (e_cyc) begin
        if (wbif.ack_i) begin
          e_cyc <= 0; e_rv <= 1; e_err <= 0;
          e_rdat <= e_we ? 8'h00 : wbif.dat_i;
        end else if (m_stb == T) begin
          e_cyc <= 0; e_rv <= 1; e_err <= 1; e_rdat <= 8'h00;
        end else begin
          m_stb <= m_stb + 1;
        end
      end else if (e_rv) begin
        if (rsp_ready) begin
          e_rv <= 0; e_busy <= 0; e_ready <= 1;
        end
      end else begin
        e_ready <= 1;
      end
    end
  end

  // ---------------- literal expectations posted by the sequence ----------------
  string       lit_nm  [64];
  logic [31:0] lit_act [64];
  logic [31:0] lit_exp [64];
  int          lit_wr = 0;
  logic        chk_on = 1'b0;
  logic        done = 1'b0;

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    if (lit_wr < 64) begin
      lit_nm[lit_wr]  = n;
      lit_act[lit_wr] = a;
      lit_exp[lit_wr] = e;
      lit_wr = lit_wr + 1;
    end
  endtask

  // ---------------- compare process (sole owner of the counters) ----------------
  int n_chk = 0;
  int n_pass = 0;
  int lit_rd = 0;

  function automatic void cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk = n_chk + 1;
    if (a === e) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", n, a, e, $time);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("cmd_ready_o", 32'(cmd_ready), 32'(e_ready));
      cmp("cyc_o",       32'(wbif.cyc_o), 32'(e_cyc));
      cmp("stb_o",       32'(wbif.stb_o), 32'(e_cyc));
      cmp("rsp_valid_o", 32'(rsp_valid), 32'(e_rv));
      cmp("busy_o",      32'(busy), 32'(e_busy));
      cmp("irq_o",       32'(irq), 32'(e_irq));
      cmp("irq_rise_o",  32'(irq_rise), 32'(e_rise));
      if (e_cyc) begin
        cmp("adr_o", 32'(wbif.adr_o), 32'(e_adr));
        cmp("we_o",  32'(wbif.we_o), 32'(e_we));
        cmp("dat_o", 32'(wbif.dat_o), 32'(e_dat));
      end
      if (e_rv) begin
        cmp("rsp_dat_o", 32'(rsp_dat), 32'(e_rdat));
        cmp("rsp_err_o", 32'(rsp_err), 32'(e_err));
      end
    end
    while (lit_rd < lit_wr) begin
      cmp(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd = lit_rd + 1;
    end
    if (done) begin
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=100000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic we, input logic [2:0] a, input logic [7:0] d, output int acc);
    bit ok;
    ok = 0;
    acc = 0;
    cmd_we = we; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = ecnt;
        ok = 1;
      end
    end
    if (!ok) begin
      cmd_valid = 1'b0;
      post("cmd_accept_timeout", 0, 1);
    end
  endtask

  // Run one command with rsp_ready high; lat counts cycles from the accept
  // edge to the first cycle with rsp_valid_o (3 for ack one cycle after stb).
  task automatic run_txn(input logic we, input logic [2:0] a, input logic [7:0] d,
                         output int lat, output int ncyc, output logic [7:0] rd,
                         output logic er, output logic [7:0] wd, output logic w);
    int acc;
    bit got;
    got = 0; ncyc = 0; lat = 0; rd = 8'hxx; er = 1'bx; wd = 8'hxx; w = 1'bx;
    send(we, a, d, acc);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (wbif.cyc_o) begin
        ncyc = ncyc + 1; wd = wbif.dat_o; w = wbif.we_o;
      end
      if (rsp_valid) begin
        got = 1; lat = ecnt - acc + 1; rd = rsp_dat; er = rsp_err;
      end
    end
    if (!got) post("rsp_wait_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, ncyc, acc, h, cnt, cnt2, unstable;
    logic [7:0] rd, wd, hold_dat;
    logic er, w, hold_err;
    bit got;

    wbif.inta_i = 1'b0;
    #2 rst = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clk);
    post("reset_cmd_ready", 32'(cmd_ready), 0);
    post("reset_cyc",       32'(wbif.cyc_o), 0);
    post("reset_rsp_valid", 32'(rsp_valid), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    post("ready_after_release", 32'(cmd_ready), 1);

    // write SPCR <= 0x50, ack one cycle after stb; dat_i junk must not leak
    ack_dly = 1; rd_val = 8'hEE;
    run_txn(1'b1, SPCR, 8'h50, lat, ncyc, rd, er, wd, w);
    post("wr_latency",  32'(lat), 3);
    post("wr_cyc_cnt",  32'(ncyc), 2);
    post("wr_dat_o",    32'(wd), 32'h50);
    post("wr_we_o",     32'(w), 1);
    post("wr_rsp_dat",  32'(rd), 0);
    post("wr_rsp_err",  32'(er), 0);

    // read SPDR -> 0xA5; write data must be ignored on the bus
    rd_val = 8'hA5;
    run_txn(1'b0, SPDR, 8'hFF, lat, ncyc, rd, er, wd, w);
    post("rd_latency",  32'(lat), 3);
    post("rd_rsp_dat",  32'(rd), 32'hA5);
    post("rd_rsp_err",  32'(er), 0);
    post("rd_dat_o",    32'(wd), 0);

    // second read pattern, ack two cycles after stb
    ack_dly = 2; rd_val = 8'h5A;
    run_txn(1'b0, SPER, 8'h00, lat, ncyc, rd, er, wd, w);
    post("rd2_latency", 32'(lat), 4);
    post("rd2_rsp_dat", 32'(rd), 32'h5A);

    // timeout: no ack, response held so a stray ack can hit RESP
    ack_dly = 0; rd_val = 8'h77; rsp_ready = 1'b0;
    send(1'b0, SPSR, 8'h00, acc);
    cnt = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (wbif.stb_o) cnt = cnt + 1;
      if (rsp_valid) got = 1;
    end
    post("to_stb_cycles", 32'(cnt), T);
    post("to_rsp_err",    32'(rsp_err), 1);
    post("to_rsp_dat",    32'(rsp_dat), 0);
    @(posedge clk); #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    @(negedge clk);
    post("stray_rsp_valid", 32'(rsp_valid), 1);
    post("stray_rsp_err",   32'(rsp_err), 1);
    post("stray_cyc",       32'(wbif.cyc_o), 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // back-pressure with a second command already waiting
    ack_dly = 1; rd_val = 8'hEE; rsp_ready = 1'b0;
    send(1'b1, SPER, 8'h11, acc);
    cmd_we = 1'b0; cmd_adr = SPDR; cmd_dat = 8'h00; cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    hold_dat = rsp_dat; hold_err = rsp_err;
    cnt = 0; cnt2 = 0; unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt  = cnt + (rsp_valid ? 1 : 0);
      cnt2 = cnt2 + (cmd_ready ? 1 : 0);
      if (rsp_dat !== hold_dat || rsp_err !== hold_err) unstable = unstable + 1;
    end
    post("bp_valid_held", 32'(cnt), 5);
    post("bp_cmd_ready",  32'(cnt2), 0);
    post("bp_unstable",   32'(unstable), 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 h = ecnt;       // response handshake edge
    rd_val = 8'hC3;
    send(1'b0, SPDR, 8'h00, acc);
    post("b2b_idle_gap", 32'(acc - h), 1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    post("b2b_rsp_dat", 32'(rsp_dat), 32'hC3);
    @(posedge clk); #1;

    // reset in the middle of a bus cycle
    ack_dly = 0;
    send(1'b0, SPSR, 8'h00, acc);
    @(negedge clk); @(negedge clk);
    post("pre_rst_cyc", 32'(wbif.cyc_o), 1);
    #2 rst = 1'b1;
    #1;
    post("rst_cyc_async",   32'(wbif.cyc_o), 0);
    post("rst_stb_async",   32'(wbif.stb_o), 0);
    post("rst_busy_async",  32'(busy), 0);
    post("rst_valid_async", 32'(rsp_valid), 0);
    @(negedge clk); #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt = cnt + (rsp_valid ? 1 : 0);
    end
    post("rst_no_rsp", 32'(cnt), 0);
    ack_dly = 1; rd_val = 8'h09;
    run_txn(1'b1, 3'd5, 8'h3E, lat, ncyc, rd, er, wd, w);
    post("post_rst_latency", 32'(lat), 3);
    post("post_rst_dat_o",   32'(wd), 32'h3E);
    post("post_rst_err",     32'(er), 0);

    // interrupt: high for 4 edges
    @(posedge clk); #1 wbif.inta_i = 1'b1;
    cnt = 0; cnt2 = 0; h = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt  = cnt + (irq ? 1 : 0);
      cnt2 = cnt2 + (irq_rise ? 1 : 0);
      if (irq && h < 0) h = i;
      @(posedge clk); #1;
      if (i == 3) wbif.inta_i = 1'b0;
    end
    post("irq_high_cycles", 32'(cnt), 4);
    post("irq_rise_pulses", 32'(cnt2), 1);
    post("irq_first_cycle", 32'(h), 1);

    @(negedge clk);
    done = 1'b1;
  end

endmodule
